// File: rtl/interface_hcsr04_n_if.sv
// Pin/controller bundle for the HC-SR04 interface.
// master = system controller + sensor side, slave = interface_hcsr04_n.
interface interface_hcsr04_n_if #(
    parameter int DIGITS = 3
);
    logic                  medir;
    logic                  echo;
    logic                  trigger;
    logic [4*DIGITS-1:0]   distancia;
    logic                  pronto;
    logic                  timeout;
    logic                  ocupado;
    logic [2:0]            db_estado;

    modport master (
        output medir,
        output echo,
        input  trigger,
        input  distancia,
        input  pronto,
        input  timeout,
        input  ocupado,
        input  db_estado
    );

    modport slave (
        input  medir,
        input  echo,
        output trigger,
        output distancia,
        output pronto,
        output timeout,
        output ocupado,
        output db_estado
    );
endinterface

// File: rtl/interface_hcsr04_n.sv
// HC-SR04 trigger/echo controller producing a rounded, saturating BCD distance.
// Define HCSR04_TIMEOUT_EN to build the echo watchdog and the erro state.
module interface_hcsr04_n #(
    parameter int TRIG_CLOCKS    = 500,
    parameter int R              = 2941,
    parameter int DIGITS         = 3,
    parameter int TIMEOUT_CLOCKS = 1500000
) (
    input logic                 clock,
    input logic                 reset,
    interface_hcsr04_n_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int TW = $clog2(R);
    localparam int CW = $clog2(TRIG_CLOCKS + 1);

    localparam logic [W-1:0]  ALL9      = {DIGITS{4'h9}};
    localparam logic [TW-1:0] TICK_MAX  = TW'(R - 1);
    localparam logic [TW-1:0] HALF      = TW'(R / 2);
    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CLOCKS - 1);

    if (R < 2 || TIMEOUT_CLOCKS < 2) begin : g_bad_param
        $error("interface_hcsr04_n: R and TIMEOUT_CLOCKS must be >= 2");
    end

    typedef enum logic [2:0] {
        S_INICIAL = 3'd0,
        S_PREP    = 3'd1,
        S_TRIG    = 3'd2,
        S_ESPERA  = 3'd3,
        S_MEDIDA  = 3'd4,
        S_ARMAZ   = 3'd5,
        S_FINAL   = 3'd6,
        S_ERRO    = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic          echo_m_q, echo_s_q;
    logic [CW-1:0] trig_q, trig_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [W-1:0]  bcd_q, bcd_d;
    logic [W-1:0]  dist_q, dist_d;
    logic          in_window;

    // Decimal +1 that sticks at all 9s
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        if (v == ALL9) return v;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign in_window = (state_q == S_ESPERA) || (state_q == S_MEDIDA);

`ifdef HCSR04_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CLOCKS);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CLOCKS - 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          timeout_q, timeout_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        trig_d  = trig_q;
        tick_d  = tick_q;
        bcd_d   = bcd_q;
        dist_d  = dist_q;
`ifdef HCSR04_TIMEOUT_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
`endif
        if (in_window && echo_s_q) begin
            if (tick_q == TICK_MAX) begin
                tick_d = '0;
                bcd_d  = bcd_inc(bcd_q);
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end

        unique case (state_q)
            S_INICIAL: if (bus.medir) state_d = S_PREP;
            S_PREP: begin
                trig_d  = '0;
                tick_d  = '0;
                bcd_d   = '0;
`ifdef HCSR04_TIMEOUT_EN
                wd_d      = '0;
                timeout_d = 1'b0;
`endif
                state_d = S_TRIG;
            end
            S_TRIG: begin
                if (trig_q == TRIG_LAST) state_d = S_ESPERA;
                else                     trig_d  = trig_q + 1'b1;
            end
            S_ESPERA: if (echo_s_q)  state_d = S_MEDIDA;
            S_MEDIDA: if (!echo_s_q) state_d = S_ARMAZ;
            S_ARMAZ: begin
                dist_d  = (tick_q >= HALF) ? bcd_inc(bcd_q) : bcd_q;
                state_d = S_FINAL;
            end
            S_FINAL: state_d = S_INICIAL;
            S_ERRO:  state_d = S_INICIAL;
            default: state_d = S_INICIAL;
        endcase

`ifdef HCSR04_TIMEOUT_EN
        // Watchdog expiry beats any echo-driven transition this cycle
        if (in_window) begin
            if (wd_q == WD_LAST) begin
                state_d   = S_ERRO;
                dist_d    = ALL9;
                timeout_d = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_INICIAL;
            echo_m_q <= 1'b0;
            echo_s_q <= 1'b0;
            trig_q   <= '0;
            tick_q   <= '0;
            bcd_q    <= '0;
            dist_q   <= '0;
        end else begin
            state_q  <= state_d;
            echo_m_q <= bus.echo;
            echo_s_q <= echo_m_q;
            trig_q   <= trig_d;
            tick_q   <= tick_d;
            bcd_q    <= bcd_d;
            dist_q   <= dist_d;
        end
    end

    assign bus.trigger   = (state_q == S_TRIG);
    assign bus.pronto    = (state_q == S_FINAL) || (state_q == S_ERRO);
    assign bus.ocupado   = (state_q != S_INICIAL);
    assign bus.db_estado = state_q;
    assign bus.distancia = dist_q;
endmodule

// File: tb/tb_interface_hcsr04_n.sv
// Randomised bench for interface_hcsr04_n against an arithmetic distance model.
// Instance A: 3 digits, TIMEOUT 2000; instance B: 2 digits, TIMEOUT 100000.
module tb_interface_hcsr04_n;
    localparam int TRIG = 10;
    localparam int RR   = 20;
    localparam int TMO  = 2000;

    logic clock = 1'b0;
    logic reset;
    logic sel;
    logic medir_v, echo_v;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] m_dist;
    logic        m_to;
    logic        m_to_trig;
    int          m_lat;
    int          m_np;

    always #5 clock = ~clock;

    interface_hcsr04_n_if #(.DIGITS(3)) bus_a();
    interface_hcsr04_n_if #(.DIGITS(2)) bus_b();

    interface_hcsr04_n #(
        .TRIG_CLOCKS(TRIG), .R(RR), .DIGITS(3), .TIMEOUT_CLOCKS(TMO)
    ) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a)
    );

    interface_hcsr04_n #(
        .TRIG_CLOCKS(TRIG), .R(RR), .DIGITS(2), .TIMEOUT_CLOCKS(100000)
    ) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b)
    );

    assign bus_a.medir = medir_v & ~sel;
    assign bus_a.echo  = echo_v  & ~sel;
    assign bus_b.medir = medir_v &  sel;
    assign bus_b.echo  = echo_v  &  sel;

    wire        obs_trig   = sel ? bus_b.trigger   : bus_a.trigger;
    wire        obs_pronto = sel ? bus_b.pronto    : bus_a.pronto;
    wire        obs_to     = sel ? bus_b.timeout   : bus_a.timeout;
    wire        obs_ocup   = sel ? bus_b.ocupado   : bus_a.ocupado;
    wire [2:0]  obs_db     = sel ? bus_b.db_estado : bus_a.db_estado;
    wire [11:0] obs_dist   = sel ? {4'h0, bus_b.distancia} : bus_a.distancia;

    // Round-to-nearest centimetres, clipped to the digit count, in BCD
    function automatic logic [11:0] ref_bcd(input int n, input int digits);
        int          v;
        int          lim;
        logic [11:0] res;
        v = n / RR;
        if ((n % RR) >= RR / 2) v++;
        lim = 1;
        for (int i = 0; i < digits; i++) lim *= 10;
        if (v > lim - 1) v = lim - 1;
        res = '0;
        for (int i = 0; i < 3; i++) begin
            res[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return res;
    endfunction

    task automatic start_meas();
        int k;
        @(negedge clock); medir_v = 1'b1;
        @(negedge clock); medir_v = 1'b0;
        k = 0;
        while (!obs_trig && k < 20) begin
            @(negedge clock);
            k++;
        end
        m_to_trig = obs_to;
        k = 0;
        while (obs_trig && k < 40) begin
            @(negedge clock);
            k++;
        end
        n_checks++;
        if (k != TRIG) begin
            n_fail++;
            $display("FAIL trig_width: got %0d cycles, expected %0d", k, TRIG);
        end
    endtask

    task automatic echo_phase(input int n, input bit poke);
        m_np = 0; m_lat = 0; m_dist = '0; m_to = 1'b0;
        echo_v = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (poke && i == n / 2) medir_v = 1'b1;
            @(negedge clock);
            medir_v = 1'b0;
        end
        echo_v = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (obs_pronto) begin
                if (m_np == 0) begin
                    m_lat  = i;
                    m_dist = obs_dist;
                    m_to   = obs_to;
                end
                m_np++;
            end
        end
        n_checks++;
        if (m_np == 0) begin
            n_fail++;
            $display("FAIL pronto_wait: got none within 60 cycles, expected 1");
        end
    endtask

    task automatic meas(input int n, input int dly, input bit poke);
        start_meas();
        repeat (dly) @(negedge clock);
        echo_phase(n, poke);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({obs_trig, obs_pronto, obs_to, obs_ocup} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {obs_trig, obs_pronto, obs_to, obs_ocup});
        end
        n_checks++;
        if (obs_dist !== 12'h000 || obs_db !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got dist=%h db=%0d expected 000/0", obs_dist, obs_db);
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (obs_ocup !== 1'b0 || obs_db !== 3'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got ocupado=%b db=%0d expected 0/0", obs_ocup, obs_db);
        end
    endtask

    task automatic test_basic();
        int first, last, hi;
        logic [11:0] exp;
        @(negedge clock); medir_v = 1'b1;
        @(negedge clock); medir_v = 1'b0;
        n_checks++;
        if (obs_db !== 3'd1 || obs_trig !== 1'b0) begin
            n_fail++;
            $display("FAIL prep_state: got db=%0d trig=%b expected 1/0", obs_db, obs_trig);
        end
        first = -1; last = -1; hi = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (obs_trig) begin
                if (first < 0) first = i;
                last = i;
                hi++;
            end
        end
        n_checks++;
        if (first != 0 || last != TRIG - 1 || hi != TRIG) begin
            n_fail++;
            $display("FAIL trig_window: got first=%0d last=%0d n=%0d expected 0/%0d/%0d",
                     first, last, hi, TRIG - 1, TRIG);
        end
        n_checks++;
        if (obs_db !== 3'd3) begin
            n_fail++;
            $display("FAIL espera_state: got %0d expected 3", obs_db);
        end
        echo_phase(100, 1'b0);
        exp = ref_bcd(100, 3);
        n_checks++;
        if (m_dist !== exp || m_to !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_dist: got %h/%b expected %h/0", m_dist, m_to, exp);
        end
        n_checks++;
        if (m_lat != 4 || m_np != 1) begin
            n_fail++;
            $display("FAIL basic_pronto: got lat=%0d n=%0d expected 4/1", m_lat, m_np);
        end
    endtask

    task automatic test_rounding();
        int          tbl [4] = '{109, 110, 19, 9};
        logic [11:0] exp;
        for (int i = 0; i < 4; i++) begin
            meas(tbl[i], 0, 1'b0);
            exp = ref_bcd(tbl[i], 3);
            n_checks++;
            if (m_dist !== exp) begin
                n_fail++;
                $display("FAIL round_%0d: got %h expected %h", tbl[i], m_dist, exp);
            end
        end
    endtask

    task automatic test_saturation();
        int          tbl [2] = '{2100, 1990};
        logic [11:0] exp;
        sel = 1'b1;
        for (int i = 0; i < 2; i++) begin
            meas(tbl[i], 1, 1'b0);
            exp = ref_bcd(tbl[i], 2);
            n_checks++;
            if (m_dist !== exp || m_np != 1) begin
                n_fail++;
                $display("FAIL sat_%0d: got %h n=%0d expected %h n=1", tbl[i], m_dist, m_np, exp);
            end
        end
        sel = 1'b0;
    endtask

`ifdef HCSR04_TIMEOUT_EN
    task automatic test_timeout();
        int cnt;
        start_meas();
        cnt = 0;
        while (!obs_pronto && cnt < TMO + 100) begin
            @(negedge clock);
            cnt++;
        end
        n_checks++;
        if (cnt != TMO) begin
            n_fail++;
            $display("FAIL tmo_delay: got %0d expected %0d", cnt, TMO);
        end
        n_checks++;
        if (obs_dist !== 12'h999 || obs_to !== 1'b1 || obs_db !== 3'd7) begin
            n_fail++;
            $display("FAIL tmo_out: got %h/%b/%0d expected 999/1/7", obs_dist, obs_to, obs_db);
        end
        repeat (5) @(negedge clock);
        n_checks++;
        if (obs_to !== 1'b1 || obs_ocup !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_hold: got to=%b ocup=%b expected 1/0", obs_to, obs_ocup);
        end
        start_meas();
        n_checks++;
        if (m_to_trig !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_clear: got %b expected 0", m_to_trig);
        end
        echo_phase(40, 1'b0);
        n_checks++;
        if (m_dist !== ref_bcd(40, 3) || m_to !== 1'b0) begin
            n_fail++;
            $display("FAIL after_tmo: got %h/%b expected %h/0", m_dist, m_to, ref_bcd(40, 3));
        end
    endtask
`else
    task automatic test_no_watchdog();
        start_meas();
        repeat (5000) @(negedge clock);
        n_checks++;
        if (obs_ocup !== 1'b1 || obs_db !== 3'd3 || obs_to !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_forever: got ocup=%b db=%0d to=%b expected 1/3/0",
                     obs_ocup, obs_db, obs_to);
        end
        echo_phase(40, 1'b0);
        n_checks++;
        if (m_dist !== ref_bcd(40, 3) || m_np != 1) begin
            n_fail++;
            $display("FAIL late_echo: got %h n=%0d expected %h n=1", m_dist, m_np, ref_bcd(40, 3));
        end
    endtask
`endif

    task automatic test_reset_mid();
        int np;
        start_meas();
        echo_v = 1'b1;
        repeat (20) @(negedge clock);
        n_checks++;
        if (obs_db !== 3'd4) begin
            n_fail++;
            $display("FAIL mid_state: got %0d expected 4", obs_db);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({obs_trig, obs_pronto, obs_to, obs_ocup} !== 4'b0000 ||
            obs_db !== 3'd0 || obs_dist !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset: got flags=%b db=%0d dist=%h expected 0000/0/000",
                     {obs_trig, obs_pronto, obs_to, obs_ocup}, obs_db, obs_dist);
        end
        @(negedge clock);
        echo_v = 1'b0;
        reset  = 1'b0;
        np = 0;
        repeat (30) begin
            @(negedge clock);
            if (obs_pronto) np++;
        end
        n_checks++;
        if (np != 0 || obs_ocup !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_pronto: got n=%0d ocup=%b expected 0/0", np, obs_ocup);
        end
    endtask

    task automatic test_medir_ignored();
        meas(60, 2, 1'b1);
        n_checks++;
        if (m_np != 1 || m_dist !== ref_bcd(60, 3)) begin
            n_fail++;
            $display("FAIL medir_busy: got n=%0d dist=%h expected 1/%h", m_np, m_dist, ref_bcd(60, 3));
        end
        n_checks++;
        if (obs_ocup !== 1'b0) begin
            n_fail++;
            $display("FAIL medir_busy_idle: got ocup=%b expected 0", obs_ocup);
        end
    endtask

    task automatic test_random();
        int          n, dly, dg;
        logic [11:0] exp;
        for (int it = 0; it < 8; it++) begin
            sel = 1'($urandom_range(0, 1));
            n   = sel ? int'($urandom_range(1, 2300)) : int'($urandom_range(1, 1500));
            dly = int'($urandom_range(0, 5));
            dg  = sel ? 2 : 3;
            meas(n, dly, 1'b0);
            exp = ref_bcd(n, dg);
            n_checks++;
            if (m_dist !== exp || m_to !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_dist n=%0d sel=%b: got %h/%b expected %h/0",
                         n, sel, m_dist, m_to, exp);
            end
            n_checks++;
            if (m_lat != 4 || m_np != 1) begin
                n_fail++;
                $display("FAIL rand_pronto n=%0d: got lat=%0d n=%0d expected 4/1", n, m_lat, m_np);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        sel     = 1'b0;
        medir_v = 1'b0;
        echo_v  = 1'b0;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
`ifdef HCSR04_TIMEOUT_EN
        test_timeout();
`else
        test_no_watchdog();
`endif
        test_reset_mid();
        test_medir_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/interface_hcsr04_n.md
# interface_hcsr04_n

Parametrised, self-contained HC-SR04 ultrasonic sensor interface: control FSM and datapath in one block. On a `medir` request it emits a trigger pulse and times the echo. It converts the echo width to centimetres in BCD with round-to-nearest and saturation, and registers the result. A configurable watchdog flags a missing or stuck echo. It sits between the sensor pins and the SmartCargo system controller, which reads `distancia` on `pronto`.

## Interface
- `TRIG_CLOCKS`, 500: trigger pulse width in clocks (10 µs at 50 MHz).
- `R`, 2941: clocks per centimetre of echo width; must be ≥ 2.
- `DIGITS`, 3: number of BCD digits in `distancia`.
- `TIMEOUT_CLOCKS`, 1500000: watchdog limit in clocks (30 ms at 50 MHz).

- `clock` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `medir` in 1: measurement request, sampled in `inicial` only.
- `echo` in 1: raw sensor echo, asynchronous; passes through a 2-FF synchroniser to give `echo_s`.
- `trigger` out 1: sensor trigger pulse.
- `distancia` out 4*DIGITS: registered BCD distance; digit 0 is at bits [3:0].
- `pronto` out 1: one-cycle pulse; `distancia` and `timeout` are valid in this cycle.
- `timeout` out 1: error flag, held until the next accepted `medir`.
- `ocupado` out 1: high in every state except `inicial`.
- `db_estado` out 3: current state encoding.

## Operation
- States and encodings:
  - `inicial`=0
  - `preparacao`=1
  - `envia_trigger`=2
  - `espera_echo`=3
  - `medida`=4
  - `armazenamento`=5
  - `final`=6
  - `erro`=7
- Transitions:
  - `inicial` → `preparacao` when `medir`=1.
  - `preparacao` → `envia_trigger` unconditionally. This state clears the tick counter, BCD counter, watchdog and `timeout`.
  - `envia_trigger` → `espera_echo` after exactly TRIG_CLOCKS cycles. `trigger` is high for exactly those cycles.
  - `espera_echo` → `medida` when `echo_s`=1.
  - `medida` → `armazenamento` when `echo_s`=0.
  - `armazenamento` → `final`. `distancia` loads the rounded count at the exiting edge.
  - `final` → `inicial`, with `pronto`=1.
  - `erro` → `inicial`, with `pronto`=1.
- Tick counter:
  - Width is clog2(R); it counts while `echo_s`=1 in `espera_echo` or `medida`.
  - N echo-high cycles give exactly N ticks.
  - On reaching R-1 it wraps to 0 and increments the BCD counter.
- BCD counter:
  - DIGITS-digit decimal counter with digit carry 9 → 0.
  - It saturates at all 9s; further increments are ignored.
- Rounding: in `armazenamento`, if the residual tick count ≥ R/2 (integer division), the stored value is the BCD counter + 1, still saturating at all 9s. Otherwise it is the BCD counter.
- `medir` is ignored while `ocupado`=1.
- The synchroniser, counters and registers use only `reset` as asynchronous clear. `preparacao` clears them synchronously.

## Timing
- Reset values:
  - State = `inicial`.
  - `trigger`=0, `pronto`=0, `timeout`=0, `ocupado`=0.
  - `distancia`=0, `db_estado`=0.
  - Synchroniser = 0.
- `medir` sampled high at edge k:
  - `preparacao` in cycle k+1.
  - `trigger` high during cycles k+2 … k+1+TRIG_CLOCKS.
- `echo` → `echo_s` latency: 2 clocks.
- From the first `echo_s`=0 cycle:
  - `armazenamento` one cycle later.
  - `final` the cycle after that, with `pronto`=1 and new `distancia` visible in the same cycle.
- An echo already high when `espera_echo` is entered is measured from that cycle.
- `reset` asserted in any state returns to reset values immediately (asynchronous). No `pronto` is generated.

## Configuration
- Macro: `HCSR04_TIMEOUT_EN`.
- Defined:
  - The watchdog counts every cycle in `espera_echo` and `medida`.
  - On reaching TIMEOUT_CLOCKS-1 the FSM goes to `erro`, overriding an `echo_s` transition in the same cycle.
  - In `erro`: `distancia` is loaded with all 9s, `timeout` is set to 1, and `pronto` pulses.
- Undefined:
  - No watchdog logic is generated; the FSM waits indefinitely in `espera_echo`/`medida`.
  - `timeout` is constant 0 and state 7 is unreachable.

## Test plan
Default overrides: TRIG_CLOCKS=10, R=20, DIGITS=3, TIMEOUT_CLOCKS=2000, macro defined unless stated.

1. `medir` 1-cycle pulse → `trigger` high exactly 10 cycles starting 2 cycles after `medir`. Echo high 100 cycles → `pronto` 1 cycle, `distancia`=0x005, `timeout`=0.
2. Rounding: echo 109 cycles → 0x005. Echo 110 cycles → 0x006. Echo 19 cycles → 0x001. Echo 9 cycles → 0x000.
3. Saturation, DIGITS=2, TIMEOUT_CLOCKS=100000: echo 2100 cycles → 0x99. Echo 1990 cycles → 0x99 (99.5 rounds, saturates).
4. No echo, macro defined → `pronto` 2000 cycles after `espera_echo` is entered, `timeout`=1, `distancia`=0x999. Next `medir` clears `timeout` in `preparacao`.
5. Macro undefined, no echo for 5000 cycles → `ocupado` stays 1, `db_estado`=3, `timeout`=0. Echo of 40 cycles then arrives → `distancia`=0x002.
6. `reset` pulsed mid-`medida` → all outputs at reset values with no `pronto`. `medir` pulsed during `medida` of a normal run → ignored, exactly one `pronto` per measurement.
